// File: rtl/us_capture_pkg.sv
// rtl/us_capture_pkg.sv - shared constants and types for the ultrasonic echo capture block
// Contents: register indices (address[15:8]), capture FSM state encoding,
//           unmapped-register read value and the status word packer.
package us_capture_pkg;

    localparam logic [7:0]  REG_FIFO   = 8'h00;
    localparam logic [7:0]  REG_STATUS = 8'h01;
    localparam logic [7:0]  REG_ARMTS  = 8'h02;

    localparam logic [31:0] DEADBEEF   = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        LISTEN = 2'd2
    } state_t;

    // Status word layout seen by the HPS.
    function automatic logic [31:0] status_word(
        input logic       overflow,
        input state_t     state,
        input logic [4:0] count,
        input logic       irq_en,
        input logic       enable
    );
        return {overflow, state, 8'b0, count, 13'b0, irq_en, 1'b0, enable};
    endfunction

endpackage

// File: rtl/ts_fifo.sv
// rtl/ts_fifo.sv - synchronous 32-bit timestamp FIFO
// Ports:
//   clock, reset      clock, synchronous active-low reset
//   clear             empties the FIFO (wins over push/pop)
//   push, push_data   write request and data; accepted when not full or when popping
//   pop               read request; ignored when empty
//   head              oldest entry, 0 when empty
//   full, empty       occupancy flags
//   count             number of stored entries
module ts_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot the concurrent push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 32'h0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && reset && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/us_echo_capture.sv
// rtl/us_echo_capture.sv - ultrasonic echo timestamp capture with Avalon-MM register access
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   echo_in             asynchronous receive comparator output
//   piezo_enable        transmit-burst indicator; a rising edge arms a capture window
//   time_cnt            shared free-running timebase
//   avalon_slave_*      register slave; address[15:8] selects the register
//   echo_irq            FIFO non-empty while irq_en is set
module us_echo_capture
    import us_capture_pkg::*;
#(
    parameter int MIN_PULSE     = 4,
    parameter int BLANK_CYCLES  = 500,
    parameter int WINDOW_CYCLES = 200000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        echo_in,
    input  logic        piezo_enable,
    input  logic [31:0] time_cnt,
    input  logic [15:0] avalon_slave_address,
    input  logic        avalon_slave_write,
    input  logic [31:0] avalon_slave_writedata,
    input  logic        avalon_slave_read,
    output logic [31:0] avalon_slave_readdata,
    output logic        avalon_slave_waitrequest,
    output logic        echo_irq
);

    localparam int FW = $clog2(MIN_PULSE + 1);
    localparam int CW = $clog2(FIFO_DEPTH);

    logic          s1, s2;
    logic [FW-1:0] filt_cnt;
    logic          qualify;
    logic          piezo_prev;
    logic          piezo_rise;
    state_t        state, state_next;
    logic [31:0]   phase_cnt, phase_next;
    logic          enable, irq_en, overflow;
    logic [31:0]   arm_ts;
    logic          wait_flag;
    logic [7:0]    reg_sel;
    logic          wr_taken, rd_first, rd_done;
    logic          en_off, arm_load;
    logic [31:0]   rd_mux;
    logic          fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]   fifo_head;
    logic [CW:0]   fifo_count;
    logic          unused_bits;

    assign unused_bits = ^{avalon_slave_address[7:0], avalon_slave_writedata[31:3],
                           avalon_slave_writedata[1]};

    assign reg_sel                  = avalon_slave_address[15:8];
    assign avalon_slave_waitrequest = wait_flag && avalon_slave_read;
    assign wr_taken                 = avalon_slave_write && !avalon_slave_waitrequest;
    assign rd_first                 = avalon_slave_read && wait_flag;
    assign rd_done                  = avalon_slave_read && !wait_flag;

    // Fires once per pulse: the counter saturates at MIN_PULSE until s2 drops.
    assign qualify    = s2 && (filt_cnt == FW'(MIN_PULSE - 1));
    assign piezo_rise = piezo_enable && !piezo_prev;
    assign en_off     = wr_taken && (reg_sel == REG_STATUS) && !avalon_slave_writedata[0];
    assign arm_load   = enable && !en_off && piezo_rise;

    assign fifo_clear = wr_taken && (reg_sel == REG_FIFO);
    assign fifo_pop   = rd_done && (reg_sel == REG_FIFO);
    assign fifo_push  = qualify && (state == LISTEN);
    assign echo_irq   = !fifo_empty && irq_en;

    ts_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        // The qualify edge is MIN_PULSE+1 clocks after s1 first saw the echo.
        .push_data (time_cnt - 32'(MIN_PULSE + 1)),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state;
        phase_next = phase_cnt;
        if (!enable || en_off) begin
            state_next = IDLE;
            phase_next = '0;
        end else if (arm_load) begin
            state_next = BLANK;
            phase_next = 32'(BLANK_CYCLES - 1);
        end else begin
            case (state)
                BLANK: begin
                    if (phase_cnt == 0) begin
                        state_next = LISTEN;
                        phase_next = 32'(WINDOW_CYCLES - 1);
                    end else begin
                        phase_next = phase_cnt - 1;
                    end
                end
                LISTEN: begin
                    if (phase_cnt == 0) begin
                        state_next = IDLE;
                        phase_next = '0;
                    end else begin
                        phase_next = phase_cnt - 1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    phase_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
        end
    end

    always_comb begin
        rd_mux = DEADBEEF;
        case (reg_sel)
            REG_FIFO:   rd_mux = fifo_head;
            REG_STATUS: rd_mux = status_word(overflow, state, 5'(fifo_count), irq_en, enable);
            REG_ARMTS:  rd_mux = arm_ts;
            default:    rd_mux = DEADBEEF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1                    <= 1'b0;
            s2                    <= 1'b0;
            filt_cnt              <= '0;
            piezo_prev            <= 1'b0;
            arm_ts                <= '0;
            enable                <= 1'b0;
            irq_en                <= 1'b0;
            overflow              <= 1'b0;
            wait_flag             <= 1'b1;
            avalon_slave_readdata <= '0;
        end else begin
            s1         <= echo_in;
            s2         <= s1;
            piezo_prev <= piezo_enable;

            if (!s2) begin
                filt_cnt <= '0;
            end else if (filt_cnt != FW'(MIN_PULSE)) begin
                filt_cnt <= filt_cnt + 1'b1;
            end

            if (arm_load) arm_ts <= time_cnt;

            if (wr_taken && (reg_sel == REG_STATUS)) begin
                enable <= avalon_slave_writedata[0];
                irq_en <= avalon_slave_writedata[2];
            end

            if (fifo_clear) begin
                overflow <= 1'b0;
            end else if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end

            // Data is captured on the wait cycle so it is stable while waitrequest is low.
            if (rd_first) begin
                avalon_slave_readdata <= rd_mux;
                wait_flag             <= 1'b0;
            end else begin
                wait_flag             <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_us_echo_capture.sv
// tb/tb_us_echo_capture.sv - self-checking bench for us_echo_capture
module tb_us_echo_capture;
    import us_capture_pkg::*;

    localparam int BLANK = 500;
    localparam int WIN   = 2000;
    localparam int MP    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] start;
        int          width;
    } pulse_t;

    typedef struct {
        int offset;
        int width;
        bit pushed;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        echo_in = 1'b0;
    logic        piezo_enable = 1'b0;
    logic [31:0] time_cnt = 32'h0;
    logic [15:0] address = 16'h0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        echo_irq;

    int          checks = 0;
    int          errors = 0;
    pulse_t      pulses[$];
    logic [31:0] rises[$];
    logic [31:0] exp_q[$];
    bit          exp_ovf;

    us_echo_capture #(
        .MIN_PULSE(MP), .BLANK_CYCLES(BLANK), .WINDOW_CYCLES(WIN), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .echo_in                  (echo_in),
        .piezo_enable             (piezo_enable),
        .time_cnt                 (time_cnt),
        .avalon_slave_address     (address),
        .avalon_slave_write       (write),
        .avalon_slave_writedata   (writedata),
        .avalon_slave_read        (read),
        .avalon_slave_readdata    (readdata),
        .avalon_slave_waitrequest (waitrequest),
        .echo_irq                 (echo_irq)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit ovf, input int st, input int cnt,
                                               input bit irq, input bit en);
        return (32'(ovf) << 31) | (32'(st) << 29) | (32'(cnt) << 16) | (32'(irq) << 2) | 32'(en);
    endfunction

    // One clock: timebase advances, echo and piezo follow the current schedule.
    task automatic step();
        @(posedge clock);
        #1;
        time_cnt = time_cnt + 32'd1;
        echo_in = 1'b0;
        foreach (pulses[i]) if (time_cnt - pulses[i].start < 32'(pulses[i].width)) echo_in = 1'b1;
        piezo_enable = 1'b0;
        foreach (rises[i]) if (time_cnt - rises[i] < 32'd10) piezo_enable = 1'b1;
    endtask

    task automatic run_until(input logic [31:0] t);
        int guard = 0;
        while (time_cnt != t && guard < 20000) begin
            step();
            guard++;
        end
        if (time_cnt != t) check("run_until_timeout", time_cnt, t);
    endtask

    task automatic clear_sched();
        pulses.delete();
        rises.delete();
    endtask

    task automatic av_read(input logic [7:0] idx, output logic [31:0] data);
        int n = 0;
        address = {idx, 8'h00};
        read = 1'b1;
        #1;
        check("waitrequest_first", waitrequest, 1);
        step();
        while (waitrequest && n < 4) begin
            step();
            n++;
        end
        if (waitrequest) check("read_timeout", waitrequest, 0);
        data = readdata;
        step();
        read = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [7:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        av_read(idx, d);
        check(name, d, exp);
    endtask

    task automatic av_write(input logic [7:0] idx, input logic [31:0] data);
        address = {idx, 8'h00};
        writedata = data;
        write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [31:0] d;
        while (exp_q.size() > 0) begin
            av_read(REG_FIFO, d);
            check(name, d, exp_q.pop_front());
        end
    endtask

    // Reference: a pulse is stored when it is long enough and its qualify point
    // (start + MP + 1) lands inside the listen window following blanking.
    task automatic model_pulse(input logic [31:0] arm, input logic [31:0] start, input int width);
        logic [31:0] d;
        d = start + 32'(MP + 1) - arm;
        if (width >= MP && d > 32'(BLANK) && d <= 32'(BLANK + WIN)) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(start);
            else exp_ovf = 1'b1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[8];
        logic [31:0] a, b, t, d;
        int          w;

        tbl[0] = '{100, 10, 1'b0};
        tbl[1] = '{495, 4, 1'b0};
        tbl[2] = '{600, 3, 1'b0};
        tbl[3] = '{700, 4, 1'b1};
        tbl[4] = '{800, 1, 1'b0};
        tbl[5] = '{900, 12, 1'b1};
        tbl[6] = '{2495, 4, 1'b1};
        tbl[7] = '{2500, 6, 1'b0};

        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        check("irq_reset", echo_irq, 0);
        read_check("status_reset", REG_STATUS, 32'h0);
        read_check("arm_reset", REG_ARMTS, 32'h0);
        read_check("default_reg", 8'h07, 32'hDEADBEEF);
        read_check("pop_empty", REG_FIFO, 32'h0);
        read_check("status_after_empty_pop", REG_STATUS, 32'h0);

        av_write(REG_STATUS, 32'h1);
        rises.push_back(32'd1000);
        pulses.push_back('{32'd1600, 10});
        run_until(32'(1000 + BLANK + WIN + 20));
        read_check("basic_arm", REG_ARMTS, 32'd1000);
        read_check("basic_status", REG_STATUS, exp_status(0, 0, 1, 0, 1));
        check("irq_masked", echo_irq, 0);
        av_write(REG_STATUS, 32'h5);
        check("irq_on", echo_irq, 1);
        read_check("basic_pop", REG_FIFO, 32'd1600);
        check("irq_off", echo_irq, 0);
        read_check("basic_empty", REG_STATUS, exp_status(0, 0, 0, 1, 1));
        av_write(REG_STATUS, 32'h1);

        clear_sched();
        exp_q.delete();
        a = time_cnt + 32'd50;
        rises.push_back(a);
        for (int i = 0; i < 8; i++) begin
            pulses.push_back('{a + 32'(tbl[i].offset), tbl[i].width});
            if (tbl[i].pushed) exp_q.push_back(a + 32'(tbl[i].offset));
        end
        run_until(a + 32'(BLANK + WIN + 20));
        read_check("table_status", REG_STATUS, exp_status(0, 0, exp_q.size(), 0, 1));
        drain("table_pop");
        read_check("table_empty", REG_STATUS, exp_status(0, 0, 0, 0, 1));

        clear_sched();
        time_cnt = 32'hFFFFFF00 - 32'd40;
        rises.push_back(32'hFFFFFF00);
        pulses.push_back('{32'h00000300, 6});
        run_until(32'hFFFFFF00 + 32'(BLANK + WIN + 20));
        read_check("wrap_arm", REG_ARMTS, 32'hFFFFFF00);
        read_check("wrap_pop", REG_FIFO, 32'h00000300);

        clear_sched();
        exp_q.delete();
        a = time_cnt + 32'd50;
        rises.push_back(a);
        for (int i = 0; i < 18; i++) begin
            pulses.push_back('{a + 32'(600 + 10 * i), 5});
            if (i < DEPTH) exp_q.push_back(a + 32'(600 + 10 * i));
        end
        run_until(a + 32'(BLANK + WIN + 20));
        read_check("ovf_status", REG_STATUS, exp_status(1, 0, 16, 0, 1));
        drain("ovf_pop");
        read_check("ovf_sticky", REG_STATUS, exp_status(1, 0, 0, 0, 1));
        av_write(REG_FIFO, 32'h0);
        read_check("ovf_cleared", REG_STATUS, exp_status(0, 0, 0, 0, 1));

        clear_sched();
        a = time_cnt + 32'd50;
        rises.push_back(a);
        for (int i = 0; i < 17; i++) pulses.push_back('{a + 32'(600 + 10 * i), 5});
        run_until(a + 32'(600 + 160 + 4));
        av_read(REG_FIFO, d);
        check("fullpop_head", d, a + 32'd600);
        run_until(a + 32'(BLANK + WIN + 20));
        read_check("fullpop_status", REG_STATUS, exp_status(0, 0, 16, 0, 1));
        read_check("fullpop_next", REG_FIFO, a + 32'd610);
        av_write(REG_FIFO, 32'h0);
        read_check("clear_status", REG_STATUS, exp_status(0, 0, 0, 0, 1));
        read_check("clear_pop", REG_FIFO, 32'h0);

        clear_sched();
        exp_q.delete();
        a = time_cnt + 32'd50;
        b = a + 32'd1000;
        rises.push_back(a);
        rises.push_back(b);
        pulses.push_back('{a + 32'd600, 6});
        pulses.push_back('{b + 32'd100, 6});
        pulses.push_back('{b + 32'd700, 6});
        pulses.push_back('{b + 32'd1000, 6});
        exp_q.push_back(a + 32'd600);
        exp_q.push_back(b + 32'd700);
        run_until(b + 32'd20);
        read_check("retrig_status", REG_STATUS, exp_status(0, 1, 1, 0, 1));
        read_check("retrig_arm", REG_ARMTS, b);
        run_until(b + 32'd900);
        av_write(REG_STATUS, 32'h0);
        read_check("disable_status", REG_STATUS, exp_status(0, 0, 2, 0, 0));
        run_until(b + 32'(BLANK + WIN + 20));
        read_check("disable_hold", REG_STATUS, exp_status(0, 0, 2, 0, 0));
        drain("retrig_pop");
        av_write(REG_STATUS, 32'h1);

        for (int k = 0; k < 4; k++) begin
            clear_sched();
            exp_q.delete();
            exp_ovf = 1'b0;
            if (k % 2 == 1) time_cnt = 32'hFFFFFFFF - 32'($urandom_range(0, 3000));
            a = time_cnt + 32'(20 + $urandom_range(0, 30));
            rises.push_back(a);
            t = a + 32'($urandom_range(0, 60));
            while (t - a < 32'(BLANK + WIN + 100)) begin
                w = int'($urandom_range(1, 8));
                pulses.push_back('{t, w});
                model_pulse(a, t, w);
                t = t + 32'(w) + 32'($urandom_range(1, 150));
            end
            run_until(a + 32'(BLANK + WIN + 200));
            read_check($sformatf("rand%0d_status", k), REG_STATUS,
                       exp_status(exp_ovf, 0, exp_q.size(), 0, 1));
            drain($sformatf("rand%0d_pop", k));
            av_write(REG_FIFO, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/us_echo_capture.md
Name: us_echo_capture

Overview:
- Receive side of the ultrasonic ranging path. The rtc block drives the piezo transmitter; this block listens on the comparator output of the receive transducer.
- Each transmit burst (piezo_enable rising) opens a blanking interval and then a listen window.
- Inside the window, qualified echo rising edges are timestamped against the shared 32-bit time_cnt and queued in a FIFO.
- The HPS reads timestamps and status over the same Avalon-MM slave style as rtc (address>>8 selects the register).

Parameters:
- MIN_PULSE, 4: consecutive synchronised-high cycles required to qualify an echo edge.
- BLANK_CYCLES, 500: cycles after burst start during which echoes are ignored (direct crosstalk).
- WINDOW_CYCLES, 200000: listen window length in cycles, counted after blanking ends.
- FIFO_DEPTH, 16: timestamp FIFO entries; must be a power of two.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- echo_in  in  1  asynchronous receive comparator output.
- piezo_enable  in  1  transmit-burst indicator from rtc.
- time_cnt  in  32  free-running rtc counter, +1 per clock, wraps modulo 2^32.
- avalon_slave_address  in  16  bits [15:8] select the register.
- avalon_slave_write  in  1  write strobe.
- avalon_slave_writedata  in  32  write data.
- avalon_slave_read  in  1  read strobe.
- avalon_slave_readdata  out  32  read data.
- avalon_slave_waitrequest  out  1  read stall.
- echo_irq  out  1  high while the FIFO is non-empty and irq_en=1.

Behaviour:
Reset (reset==0 at a clock edge):
- state=IDLE; FIFO empty; overflow=0; enable=0; irq_en=0; arm_ts=0; readdata=0.
- wait flag=1, so waitrequest = read.
- All counters 0.

Input synchroniser and filter:
- echo_in passes through a 2-flop synchroniser (s1, s2).
- A filter counter increments while s2=1 and clears when s2=0.
- An edge qualifies on the cycle the counter reaches MIN_PULSE. It does not re-qualify until s2 returns to 0.
- Timestamp pushed = time_cnt sampled on the qualify edge minus (MIN_PULSE+1), modulo 2^32. This equals time_cnt at the edge where s1 first sampled 1. Wrap-around is natural 32-bit subtraction.

FSM (states IDLE, BLANK, LISTEN):
- IDLE -> BLANK: on piezo_enable rising edge (registered previous value) while enable=1. arm_ts <= time_cnt; the phase counter is loaded.
- BLANK -> LISTEN: after BLANK_CYCLES cycles. Qualified edges in BLANK are discarded.
- LISTEN -> IDLE: after WINDOW_CYCLES cycles. Qualified edges in LISTEN are pushed.
- A new piezo_enable rise in BLANK or LISTEN restarts BLANK and reloads arm_ts. The FIFO is not cleared.
- enable written to 0 forces IDLE the next cycle.

FIFO:
- Push when not full.
- Push when full: drop the new entry and set sticky overflow.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, so the push succeeds and no overflow is flagged.
- Pop on empty: returns 32'h00000000, no pointer change.

Avalon read (same protocol as rtc):
- readdata is registered.
- waitrequest = wait flag AND read. The flag clears one cycle after a read is seen, so every read has one wait cycle.
- The pop occurs once per read transaction, on the cycle waitrequest deasserts.
- Register map (address>>8):
  - 0x00: FIFO head (pop).
  - 0x01: status = {overflow[31], state[30:29], irq_en[2], enable[0], count[20:16], zeros elsewhere}.
  - 0x02: arm_ts.
  - Other addresses: 32'hDEADBEEF.

Avalon write (taken when waitrequest=0):
- 0x00: any data clears the FIFO and overflow.
- 0x01: enable=wd[0], irq_en=wd[2].
- Other addresses are ignored.
- A write clear on the same cycle as a push: the clear wins.

Decomposition:
- Package us_capture_pkg holds:
  - register index constants REG_FIFO=8'h00, REG_STATUS=8'h01, REG_ARMTS=8'h02;
  - FSM state encoding IDLE=2'd0, BLANK=2'd1, LISTEN=2'd2;
  - DEADBEEF default constant.
- One sub-module: ts_fifo. It is a synchronous 32-bit FIFO with push, pop, clear, full, empty, count, and a parameterised depth.

Test Plan:
- Reset and default read: reset low for 3 cycles, then read 0x01 -> 32'h00000000 after one wait cycle; read 0x07 -> 32'hDEADBEEF.
- Basic capture: enable=1; piezo rise at time_cnt=1000; echo_in rises so s1 first samples 1 at time_cnt=1600 and stays high 10 cycles. Expected: read 0x02 -> 1000; read 0x01 count=1; read 0x00 -> 1600; then count=0.
- Blanking and filter:
  - echo at time_cnt=arm+100 (inside BLANK) -> not pushed.
  - echo 3 cycles wide in LISTEN -> not pushed.
  - echo 4 cycles wide in LISTEN -> pushed.
- Wrap-around: arm at 32'hFFFFFF00, s1 first samples 1 at time_cnt=32'h00000300 -> pops 32'h00000300; arm_ts=32'hFFFFFF00.
- Overflow: 18 qualified echoes in one window with FIFO_DEPTH=16 -> count=16, overflow=1, the first 16 timestamps pop in order; write 0x00 -> count=0, overflow=0.
- Window end and retrigger:
  - echo at WINDOW_CYCLES+1 after blanking -> ignored; state=IDLE.
  - second piezo rise during LISTEN -> state=BLANK, arm_ts updated, FIFO contents retained.
  - enable=0 mid-LISTEN -> IDLE the next cycle.
